// File: rtl/rv_if_stage.sv
// rv_if_stage: RV32I instruction-fetch stage.
// Owns the fetch PC. Issues in-order requests to a variable-latency
// instruction memory. Responses are buffered in a 3-entry {pc, instr}
// queue, and the head of that queue is loaded into the IF/ID register.
// A redirect from EX restarts fetch at a new target. Responses that are
// still in flight at that point are counted and dropped when they arrive.
module rv_if_stage #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            i_if_clk,
    input  logic            i_if_rst,
    input  logic            i_if_stall,
    input  logic            i_if_flush,
    input  logic            i_if_redirect,
    input  logic [XLEN-1:0] i_if_redirect_pc,
    output logic            o_if_imem_req,
    output logic [XLEN-1:0] o_if_imem_addr,
    input  logic            i_if_imem_ready,
    input  logic            i_if_imem_rvalid,
    input  logic [31:0]     i_if_imem_rdata,
    output logic [XLEN-1:0] o_if_id_pc,
    output logic [31:0]     o_if_id_instr
);

    localparam int DEPTH = 3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } ibuf_ent_t;

    // Fetch-side state
    logic [XLEN-1:0] fetch_pc;
    logic [1:0]      ofl;                 // accepted, not yet answered
    logic [1:0]      drp;                 // in-flight answers to discard
    logic [XLEN-1:0] tag_q   [DEPTH];     // request PCs, oldest at [0]
    logic [XLEN-1:0] tag_nxt [DEPTH];

    // Instruction buffer, oldest at [0]
    ibuf_ent_t       buf_q   [DEPTH];
    ibuf_ent_t       buf_nxt [DEPTH];
    logic [1:0]      cnt;

    // IF/ID register
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;

    // Handshake terms
    logic            credit_ok;
    logic            acc;
    logic            rsp;
    logic            push;
    logic            pop;
    logic [1:0]      ofl_nxt;
    logic [1:0]      tag_wr;
    logic [1:0]      buf_wr;

    // Requests are limited by credit. An in-flight slot and a buffered
    // slot each use one credit, so an accepted request always has room
    // to land in the buffer.
    always_comb begin
        credit_ok = ({1'b0, ofl} + {1'b0, cnt}) < 3'd3;
        acc       = o_if_imem_req && i_if_imem_ready;
        rsp       = i_if_imem_rvalid && (ofl != 2'd0);
        push      = rsp && (drp == 2'd0) && !i_if_redirect;
        pop       = !i_if_flush && !i_if_stall && (cnt != 2'd0) && !i_if_redirect;
        ofl_nxt   = ofl + {1'b0, acc} - {1'b0, rsp};
        tag_wr    = ofl - {1'b0, rsp};
        buf_wr    = cnt - {1'b0, pop};
    end

    // The request is suppressed during reset and in a redirect cycle.
    always_comb begin
        o_if_imem_req  = !i_if_rst && !i_if_redirect && credit_ok;
        o_if_imem_addr = fetch_pc;
    end

    // Next contents of the tag queue: shift out on a response, append on acceptance.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) tag_nxt[i] = tag_q[i];
        if (rsp) begin
            for (int i = 0; i < DEPTH - 1; i++) tag_nxt[i] = tag_q[i+1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (acc && (tag_wr == 2'(i))) tag_nxt[i] = fetch_pc;
        end
    end

    // Next contents of the buffer: shift out on a pop, append a kept response.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) buf_nxt[i] = buf_q[i];
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) buf_nxt[i] = buf_q[i+1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (buf_wr == 2'(i))) begin
                buf_nxt[i].pc    = tag_q[0];
                buf_nxt[i].instr = i_if_imem_rdata;
            end
        end
    end

    // Update the fetch PC and the in-flight/discard counters. A redirect wins over acceptance.
    always_ff @(posedge i_if_clk) begin
        if (i_if_rst) begin
            fetch_pc <= RESET_PC;
            ofl      <= 2'd0;
            drp      <= 2'd0;
        end else begin
            ofl <= ofl_nxt;
            if (i_if_redirect) begin
                fetch_pc <= i_if_redirect_pc;
                drp      <= ofl_nxt;
            end else begin
                if (acc) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp && (drp != 2'd0)) drp <= drp - 2'd1;
            end
        end
    end

    // Update the payload storage. Validity is tracked by ofl and cnt, so this storage needs no reset.
    always_ff @(posedge i_if_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= tag_nxt[i];
            buf_q[i] <= buf_nxt[i];
        end
    end

    // Update the buffer occupancy. A redirect empties the buffer, and that includes a response arriving in the same cycle.
    always_ff @(posedge i_if_clk) begin
        if (i_if_rst)           cnt <= 2'd0;
        else if (i_if_redirect) cnt <= 2'd0;
        else                    cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end

    // Update the IF/ID register. A flush loads a bubble, a stall holds, otherwise the register takes the buffer head or a bubble.
    always_ff @(posedge i_if_clk) begin
        if (i_if_rst) begin
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
        end else if (i_if_flush) begin
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
        end else if (!i_if_stall) begin
            if (pop) begin
                id_pc    <= buf_q[0].pc;
                id_instr <= buf_q[0].instr;
            end else begin
                id_pc    <= '0;
                id_instr <= NOP_INSTR;
            end
        end
    end

    assign o_if_id_pc    = id_pc;
    assign o_if_id_instr = id_instr;

endmodule

// File: tb/tb_rv_if_stage.sv
// tb_rv_if_stage: randomized bench for rv_if_stage.
// The reference model is built from queues: requests in flight, the
// instruction buffer, and the memory's pending responses.
module tb_rv_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redir, rdy, rvalid;
    logic [31:0] rpc, rdata;
    logic        req;
    logic [31:0] addr, id_pc, id_instr;

    rv_if_stage dut (
        .i_if_clk         (clk),
        .i_if_rst         (rst),
        .i_if_stall       (stall),
        .i_if_flush       (flush),
        .i_if_redirect    (redir),
        .i_if_redirect_pc (rpc),
        .o_if_imem_req    (req),
        .o_if_imem_addr   (addr),
        .i_if_imem_ready  (rdy),
        .i_if_imem_rvalid (rvalid),
        .i_if_imem_rdata  (rdata),
        .o_if_id_pc       (id_pc),
        .o_if_id_instr    (id_instr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    logic [31:0] m_tags[$];
    ent_t        m_buf[$];
    mreq_t       mq[$];
    int          m_drp, last_due, lmin, lmax;
    logic [31:0] m_pc, m_id_pc, m_id_instr;
    bit          m_known = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs, then advance the model.
    task automatic step(input bit r, input bit st, input bit fl, input bit rd,
                        input logic [31:0] tgt, input bit ry, input bit spur_ok);
        bit   real_rsp, exp_req, acc, rsp;
        ent_t e;
        @(posedge clk); #1;
        cyc++;
        rst = r; stall = st; flush = fl; redir = rd; rpc = tgt; rdy = ry;
        real_rsp = !r && mq.size() > 0 && mq[0].due <= cyc;
        rvalid = real_rsp;
        rdata  = real_rsp ? mem_word(mq[0].addr) : $urandom;
        if (!r && !real_rsp && spur_ok && mq.size() == 0 && $urandom_range(0, 3) == 0)
            rvalid = 1'b1;
        @(negedge clk);
        exp_req = !r && !rd && (m_tags.size() + m_buf.size() < 3);
        chk("req", {31'b0, req}, {31'b0, exp_req});
        if (m_known) begin
            chk("addr", addr, m_pc);
            chk("id_pc", id_pc, m_id_pc);
            chk("id_instr", id_instr, m_id_instr);
        end
        if (r) begin
            m_tags.delete(); m_buf.delete(); mq.delete();
            m_drp = 0; m_pc = RESET_PC; last_due = 0;
            m_id_pc = 32'h0; m_id_instr = NOP_INSTR; m_known = 1'b1;
            return;
        end
        acc = exp_req && ry;
        rsp = rvalid && m_tags.size() > 0;
        // IF/ID update is based on the buffer contents before this cycle's response
        if (fl) begin
            m_id_pc = 32'h0; m_id_instr = NOP_INSTR;
        end else if (!st) begin
            if (m_buf.size() > 0 && !rd) begin
                e = m_buf.pop_front();
                m_id_pc = e.pc; m_id_instr = e.instr;
            end else begin
                m_id_pc = 32'h0; m_id_instr = NOP_INSTR;
            end
        end
        if (real_rsp) void'(mq.pop_front());
        if (rsp) begin
            e.pc = m_tags.pop_front();
            e.instr = rdata;
            if (m_drp > 0) m_drp--;
            else if (!rd) m_buf.push_back(e);
        end
        if (rd) begin
            m_buf.delete();
            m_drp = m_tags.size();
            m_pc = tgt;
        end else if (acc) begin
            mreq_t q;
            int d;
            m_tags.push_back(m_pc);
            d = cyc + $urandom_range(lmin, lmax);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            q.addr = m_pc; q.due = d;
            mq.push_back(q);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic idle(input int n, input bit st);
        for (int i = 0; i < n; i++) step(1'b0, st, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic rnd_phase(input int n, input int p_rdy, input int p_st, input int p_fl,
                             input int p_rd, input int pm_rst, input bit wrap);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = wrap && $urandom_range(0, 1) ? 32'hFFFF_FFF0 + {28'h0, $urandom_range(0, 3), 2'b00}
                                             : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            step($urandom_range(0, 999) < pm_rst,
                 $urandom_range(0, 99) < p_st,
                 $urandom_range(0, 99) < p_fl,
                 $urandom_range(0, 99) < p_rd,
                 t,
                 $urandom_range(0, 99) < p_rdy,
                 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = 32'h0;
        rdy = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        lmin = 1; lmax = 1;

        // 1-cycle memory: sequential stream after a 3-cycle fill
        step(1'b1, 0, 0, 0, 0, 1, 0);
        step(1'b1, 0, 0, 0, 0, 1, 0);
        idle(12, 1'b0);
        // ready low for 5 cycles, then resume
        for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle(8, 1'b0);
        // stall long enough for the buffer to fill, then release
        idle(6, 1'b1);
        idle(6, 1'b0);
        // flush and stall together
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 0);
        idle(4, 1'b0);

        // 3-cycle memory: redirect with requests in flight
        lmin = 3; lmax = 3;
        idle(5, 1'b0);
        step(1'b0, 0, 0, 1'b1, 32'h0000_0100, 1, 0);
        idle(12, 1'b0);
        // redirect, stall and a response in the same cycle
        lmin = 2; lmax = 2;
        idle(6, 1'b0);
        step(1'b0, 1'b1, 0, 1'b1, 32'h0000_0200, 1, 0);
        idle(10, 1'b0);
        // fetch PC wraparound
        lmin = 1; lmax = 1;
        step(1'b0, 0, 0, 1'b1, 32'hFFFF_FFF8, 1, 0);
        idle(10, 1'b0);

        // Randomized mixes
        lmin = 1; lmax = 4;
        rnd_phase(400, 70, 20, 5, 5, 0, 1'b0);
        rnd_phase(400, 50, 30, 10, 10, 8, 1'b1);
        lmin = 1; lmax = 2;
        rnd_phase(300, 90, 5, 2, 3, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rv_if_stage.md
# rv_if_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory, with up to three instructions in flight or buffered. Responses go into a 3-entry instruction buffer. The block drives the IF/ID pipeline register that feeds the decode stage, and handles hazard-unit stalls and branch/jump redirects from EX, including discarding stale in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: `addi x0,x0,0`, inserted as the bubble.
- i_if_clk  in  1  sole clock; all state updates on its rising edge.
- i_if_rst  in  1  reset: one clock; reset is synchronous and active-high.
- i_if_stall  in  1  from hazard unit; hold the IF/ID register and do not pop the buffer.
- i_if_flush  in  1  from EX; load a bubble into IF/ID.
- i_if_redirect  in  1  from EX; taken branch/jal/jalr.
- i_if_redirect_pc  in  `XLEN  redirect target; word-aligned.
- o_if_imem_req  out  1  fetch request valid.
- o_if_imem_addr  out  `XLEN  fetch address (= fetch PC).
- i_if_imem_ready  in  1  memory accepts the request this cycle.
- i_if_imem_rvalid  in  1  response valid; in order; no backpressure.
- i_if_imem_rdata  in  32  response instruction.
- o_if_id_pc  out  `XLEN  IF/ID PC.
- o_if_id_instr  out  32  IF/ID instruction.

## Operation
- State:
  - fetch_pc
  - ofl (0..3): accepted requests not yet responded.
  - drp (0..ofl): in-flight responses to discard.
  - 3-entry FIFO of {pc, instr} with count (0..3).
  - Per-request PC tags are kept alongside ofl, so each response is paired with its request address.
- Request: o_if_imem_req = !i_if_redirect && (ofl + count < 3). o_if_imem_addr = fetch_pc.
- Acceptance (req && ready): ofl increments, fetch_pc += 4 (mod 2^XLEN, wraps silently), and the tag is pushed.
- Response (rvalid): ofl decrements and the tag is popped.
  - If drp > 0: discard the response, drp decrements.
  - Otherwise push {tag pc, rdata} into the FIFO.
  - rvalid with ofl == 0 is illegal and is ignored.
- Redirect, which takes priority over everything in the fetch side:
  - fetch_pc <= i_if_redirect_pc.
  - FIFO cleared, including any response arriving in the same cycle.
  - drp <= ofl remaining after this cycle's response.
  - No request is issued in the redirect cycle.
- IF/ID update, in priority order:
  - i_if_flush: load {0, NOP_INSTR}. Nothing is popped. Flush overrides stall.
  - else i_if_stall: hold.
  - else count > 0 and no redirect this cycle: pop the head into IF/ID.
  - else: load {0, NOP_INSTR}.
- Simultaneous push and pop in one cycle: count is unchanged and order is preserved. A full FIFO cannot overflow, because the credit rule guarantees space.

## Timing
- Reset values:
  - o_if_imem_req = 0 during reset; o_if_imem_addr = RESET_PC.
  - o_if_id_pc = 0; o_if_id_instr = NOP_INSTR.
  - ofl = drp = count = 0.
- First request is asserted in the first cycle after reset deasserts.
- No combinational path from rvalid/rdata to the IF/ID outputs. A response arriving in cycle t is written to the FIFO at the end of t, loaded into IF/ID at the end of t+1, and visible at t+2.
- With a 1-cycle memory (accept at t, rvalid at t+1) and no stalls, IF/ID sustains one new instruction per cycle after a 3-cycle fill.
- Redirect asserted in cycle t:
  - First request to the target goes out at t+1.
  - IF/ID shows bubbles until the target instruction arrives.
- Reset mid-operation clears all counters and the FIFO immediately. The memory is reset on the same reset, so no stale responses arrive afterwards.

## Test plan
- Reset, 1-cycle memory, sequential instruction words at 0x0,0x4,… -> IF/ID shows NOP for 3 cycles, then pc 0x0,0x4,0x8 on consecutive cycles; req never deasserts.
- ready low for 5 cycles -> req held, addr stable at its value, IF/ID shows NOP bubbles once the FIFO drains; resumes with no skipped or duplicated PC.
- Stall for 4 cycles with FIFO filling -> IF/ID holds pc 0x8; count reaches 3 and req drops; on release, 0xC,0x10,0x14 appear back-to-back.
- 3-cycle memory latency, redirect to 0x100 with 2 requests in flight -> both late responses discarded; next IF/ID non-NOP is pc 0x100.
- Flush and stall asserted together -> IF/ID = {0, 0x00000013}, FIFO count unchanged.
- Redirect in the same cycle as rvalid and stall -> that response is dropped, the FIFO is empty, fetch_pc equals the target, and IF/ID is held.
